// File: rtl/apb_pkg.sv
// Shared definitions for the APB GPIO slave: transfer FSM encoding,
// register index map and the byte-lane write merge helper.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } apb_state_t;

  localparam logic [2:0] REG_DOUT = 3'd0;
  localparam logic [2:0] REG_DIR  = 3'd1;
  localparam logic [2:0] REG_DIN  = 3'd2;
  localparam logic [2:0] REG_IE   = 3'd3;
  localparam logic [2:0] REG_IS   = 3'd4;
  localparam logic [2:0] REG_POL  = 3'd5;

  // Merge works on a fixed wide word; callers zero-extend and slice back.
  localparam int MERGE_WIDTH = 64;
  localparam int MERGE_STRB  = MERGE_WIDTH / 8;

  function automatic logic [MERGE_WIDTH-1:0] strb_merge(
    input logic [MERGE_WIDTH-1:0] old_word,
    input logic [MERGE_WIDTH-1:0] new_word,
    input logic [MERGE_STRB-1:0]  strb
  );
    logic [MERGE_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MERGE_STRB; i++) begin
      if (strb[i]) begin
        merged[i*8 +: 8] = new_word[i*8 +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// GPIO input path: two-flop synchroniser, one-cycle delayed copy and a
// polarity-selectable edge detector that stays quiet until primed.
module gpio_in_sync #(
  parameter int GPIO_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [GPIO_WIDTH-1:0] i_pins,
  input  logic [GPIO_WIDTH-1:0] i_pol,
  output logic [GPIO_WIDTH-1:0] o_din,
  output logic [GPIO_WIDTH-1:0] o_edge
);

  logic [GPIO_WIDTH-1:0] r_meta;
  logic [GPIO_WIDTH-1:0] r_din;
  logic [GPIO_WIDTH-1:0] r_din_q;
  logic [1:0]            r_prime;
  logic                  w_primed;
  logic [GPIO_WIDTH-1:0] w_rise;
  logic [GPIO_WIDTH-1:0] w_fall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta  <= '0;
      r_din   <= '0;
      r_din_q <= '0;
      r_prime <= 2'd0;
    end else begin
      r_meta  <= i_pins;
      r_din   <= r_meta;
      r_din_q <= r_din;
      if (r_prime != 2'd3) begin
        r_prime <= r_prime + 2'd1;
      end
    end
  end

  // Pins already high at reset ripple through the pipeline; ignore them.
  assign w_primed = (r_prime == 2'd3);
  assign w_rise   = r_din & ~r_din_q;
  assign w_fall   = ~r_din & r_din_q;
  assign o_edge   = w_primed ? ((w_rise & ~i_pol) | (w_fall & i_pol)) : '0;
  assign o_din    = r_din;

endmodule

// File: rtl/apb_gpio_slave.sv
// APB slave exposing a small GPIO register file (DOUT, DIR, DIN, IE, IS, POL)
// with configurable wait states and a level edge-detect interrupt.
module apb_gpio_slave
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4,
  parameter int STRB_WIDTH    = 4,
  parameter int GPIO_WIDTH    = 8,
  parameter int WAIT_STATES   = 1
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [ADDRESS_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0]    PWDATA,
  input  logic [STRB_WIDTH-1:0]    PSTRB,
  output logic [DATA_WIDTH-1:0]    PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  input  logic [GPIO_WIDTH-1:0]    gpio_in,
  output logic [GPIO_WIDTH-1:0]    gpio_out,
  output logic [GPIO_WIDTH-1:0]    gpio_oe,
  output logic                     irq
);

  apb_state_t r_state;
  apb_state_t w_state_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;

  logic [GPIO_WIDTH-1:0] r_dout;
  logic [GPIO_WIDTH-1:0] r_dir;
  logic [GPIO_WIDTH-1:0] r_ie;
  logic [GPIO_WIDTH-1:0] r_is;
  logic [GPIO_WIDTH-1:0] r_pol;
  logic                  r_irq;

  logic [GPIO_WIDTH-1:0]  w_din;
  logic [GPIO_WIDTH-1:0]  w_edge;
  logic [2:0]             w_index;
  logic                   w_pready;
  logic                   w_err;
  logic                   w_commit;
  logic [GPIO_WIDTH-1:0]  w_rd_reg;
  logic [MERGE_WIDTH-1:0] w_merged_full;
  logic [MERGE_WIDTH-1:0] w_lanes_full;
  logic [GPIO_WIDTH-1:0]  w_merged;
  logic [GPIO_WIDTH-1:0]  w_clear;
  logic                   w_unused;

  gpio_in_sync #(
    .GPIO_WIDTH(GPIO_WIDTH)
  ) u_in_sync (
    .i_clk  (PCLK),
    .i_rst_n(PRESETn),
    .i_pins (gpio_in),
    .i_pol  (r_pol),
    .o_din  (w_din),
    .o_edge (w_edge)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // A setup phase is only accepted from IDLE; READY always returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          if (WAIT_STATES == 0) begin
            w_state_next = ST_READY;
          end else begin
            w_state_next = ST_WAIT;
            w_cnt_next   = 4'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_state_next = ST_READY;
          end
        end
      end
      ST_READY: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  assign w_index  = PADDR[2:0];
  assign w_pready = (r_state == ST_READY) && PSEL && PENABLE;
  assign w_err    = (w_index == 3'd6) || (w_index == 3'd7) ||
                    (PWRITE && (w_index == REG_DIN));
  assign w_commit = w_pready && PWRITE && !w_err;

  always_comb begin
    w_rd_reg = '0;
    case (w_index)
      REG_DOUT: w_rd_reg = r_dout;
      REG_DIR:  w_rd_reg = r_dir;
      REG_DIN:  w_rd_reg = w_din;
      REG_IE:   w_rd_reg = r_ie;
      REG_IS:   w_rd_reg = r_is;
      REG_POL:  w_rd_reg = r_pol;
      default:  w_rd_reg = '0;
    endcase
  end

  // Lane mask for W1C reuses the merge helper with an all-zero old word.
  assign w_merged_full = strb_merge(MERGE_WIDTH'(w_rd_reg), MERGE_WIDTH'(PWDATA),
                                    MERGE_STRB'(PSTRB));
  assign w_lanes_full  = strb_merge('0, MERGE_WIDTH'(PWDATA), MERGE_STRB'(PSTRB));
  assign w_merged      = w_merged_full[GPIO_WIDTH-1:0];
  assign w_clear       = (w_commit && (w_index == REG_IS)) ?
                         w_lanes_full[GPIO_WIDTH-1:0] : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_dout <= '0;
      r_dir  <= '0;
      r_ie   <= '0;
      r_is   <= '0;
      r_pol  <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (w_commit) begin
        case (w_index)
          REG_DOUT: r_dout <= w_merged;
          REG_DIR:  r_dir  <= w_merged;
          REG_IE:   r_ie   <= w_merged;
          REG_POL:  r_pol  <= w_merged;
          default:  ;
        endcase
      end
      // A new edge on the clear cycle wins over the W1C.
      r_is  <= (r_is & ~w_clear) | w_edge;
      r_irq <= |(r_is & r_ie);
    end
  end

  assign PREADY   = w_pready;
  assign PSLVERR  = w_pready && w_err;
  assign PRDATA   = (w_pready && !PWRITE) ? DATA_WIDTH'(w_rd_reg) : '0;
  assign gpio_out = r_dout;
  assign gpio_oe  = r_dir;
  assign irq      = r_irq;

  assign w_unused = ^{PADDR[ADDRESS_WIDTH-1:3],
                      w_merged_full[MERGE_WIDTH-1:GPIO_WIDTH],
                      w_lanes_full[MERGE_WIDTH-1:GPIO_WIDTH]};

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Directed bench for apb_gpio_slave: a register-access vector table plus
// hand sequences for interrupts, aborts and reset mid-transfer.
module tb_apb_gpio_slave;

  typedef struct {
    logic        write;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] expRdata;
    logic        expErr;
    logic [7:0]  expOut;
    logic [7:0]  expOe;
  } vector_t;

  localparam int NUM_VECS = 19;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        psel1;
  logic        psel3;
  logic        PENABLE;
  logic        PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [7:0]  gpioIn;
  logic [31:0] prdata1;
  logic [31:0] prdata3;
  logic        pready1;
  logic        pready3;
  logic        pslverr1;
  logic        pslverr3;
  logic [7:0]  out1;
  logic [7:0]  oe1;
  logic [7:0]  out3;
  logic [7:0]  oe3;
  logic        irq1;
  logic        irq3;

  int checks = 0;
  int failures = 0;
  vector_t vecs [NUM_VECS];

  always #5 PCLK = ~PCLK;

  apb_gpio_slave #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(4), .STRB_WIDTH(4), .GPIO_WIDTH(8), .WAIT_STATES(1)
  ) u_dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel1), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata1), .PREADY(pready1),
    .PSLVERR(pslverr1), .gpio_in(gpioIn), .gpio_out(out1), .gpio_oe(oe1), .irq(irq1)
  );

  apb_gpio_slave #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(4), .STRB_WIDTH(4), .GPIO_WIDTH(8), .WAIT_STATES(3)
  ) u_dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel3), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata3), .PREADY(pready3),
    .PSLVERR(pslverr3), .gpio_in(gpioIn), .gpio_out(out3), .gpio_oe(oe3), .irq(irq3)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One full APB transfer on the chosen instance; waits counts PREADY-low access cycles.
  task automatic apbXfer(input int which, input logic write, input logic [3:0] addr,
                         input logic [31:0] data, input logic [3:0] strb,
                         input logic setPin, input logic [7:0] pinVal,
                         output logic [31:0] rdata, output logic err, output int waits);
    bit done;
    waits = 0;
    rdata = '0;
    err = 1'b0;
    done = 1'b0;
    @(posedge PCLK); #1;
    if (which == 3) psel3 = 1'b1;
    else psel1 = 1'b1;
    PENABLE = 1'b0;
    PWRITE = write;
    PADDR = addr;
    PWDATA = data;
    PSTRB = strb;
    if (setPin) gpioIn = pinVal;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge PCLK);
      if ((which == 3) ? pready3 : pready1) begin
        rdata = (which == 3) ? prdata3 : prdata1;
        err = (which == 3) ? pslverr3 : pslverr1;
        done = 1'b1;
      end else begin
        waits++;
        @(posedge PCLK); #1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL xfer_timeout: PREADY got 0 expected 1");
    end
    @(posedge PCLK); #1;
    psel1 = 1'b0;
    psel3 = 1'b0;
    PENABLE = 1'b0;
  endtask

  task automatic applyStimulus(input int idx, input vector_t v);
    logic [31:0] rd;
    logic err;
    int waits;
    apbXfer(1, v.write, v.addr, v.data, v.strb, 1'b0, 8'h00, rd, err, waits);
    checkOutput($sformatf("vec%0d_prdata", idx), rd, v.expRdata);
    checkOutput($sformatf("vec%0d_pslverr", idx), 32'(err), 32'(v.expErr));
    checkOutput($sformatf("vec%0d_waits", idx), 32'(waits), 32'd1);
    checkOutput($sformatf("vec%0d_gpio_out", idx), 32'(out1), 32'(v.expOut));
    checkOutput($sformatf("vec%0d_gpio_oe", idx), 32'(oe1), 32'(v.expOe));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic err;
    int waits;
    int lat;
    bit sawReady;

    //            wr    addr   data          strb     rdata         err   out    oe
    vecs[0]  = '{1'b1, 4'h0, 32'h0000_00A5, 4'b0001, 32'h0,        1'b0, 8'hA5, 8'h00};
    vecs[1]  = '{1'b1, 4'h1, 32'h0000_00FF, 4'b0001, 32'h0,        1'b0, 8'hA5, 8'hFF};
    vecs[2]  = '{1'b1, 4'h0, 32'h0000_003C, 4'b0000, 32'h0,        1'b0, 8'hA5, 8'hFF};
    vecs[3]  = '{1'b0, 4'h0, 32'h0,         4'b0000, 32'h0000_00A5, 1'b0, 8'hA5, 8'hFF};
    vecs[4]  = '{1'b0, 4'h1, 32'h0,         4'b0000, 32'h0000_00FF, 1'b0, 8'hA5, 8'hFF};
    vecs[5]  = '{1'b1, 4'h0, 32'h0000_1234, 4'b0010, 32'h0,        1'b0, 8'hA5, 8'hFF};
    vecs[6]  = '{1'b1, 4'h0, 32'hFFFF_FF0F, 4'b0001, 32'h0,        1'b0, 8'h0F, 8'hFF};
    vecs[7]  = '{1'b0, 4'h0, 32'h0,         4'b0000, 32'h0000_000F, 1'b0, 8'h0F, 8'hFF};
    vecs[8]  = '{1'b1, 4'h2, 32'h0000_0012, 4'b1111, 32'h0,        1'b1, 8'h0F, 8'hFF};
    vecs[9]  = '{1'b0, 4'h7, 32'h0,         4'b0000, 32'h0,        1'b1, 8'h0F, 8'hFF};
    vecs[10] = '{1'b1, 4'h6, 32'h0000_00FF, 4'b1111, 32'h0,        1'b1, 8'h0F, 8'hFF};
    vecs[11] = '{1'b1, 4'h5, 32'h0000_0080, 4'b0001, 32'h0,        1'b0, 8'h0F, 8'hFF};
    vecs[12] = '{1'b0, 4'h5, 32'h0,         4'b0000, 32'h0000_0080, 1'b0, 8'h0F, 8'hFF};
    vecs[13] = '{1'b1, 4'h5, 32'h0000_0000, 4'b0001, 32'h0,        1'b0, 8'h0F, 8'hFF};
    vecs[14] = '{1'b1, 4'h8, 32'h0000_0077, 4'b0001, 32'h0,        1'b0, 8'h77, 8'hFF};
    vecs[15] = '{1'b0, 4'h0, 32'h0,         4'b0000, 32'h0000_0077, 1'b0, 8'h77, 8'hFF};
    vecs[16] = '{1'b0, 4'h2, 32'h0,         4'b0000, 32'h0,        1'b0, 8'h77, 8'hFF};
    vecs[17] = '{1'b0, 4'h4, 32'h0,         4'b0000, 32'h0,        1'b0, 8'h77, 8'hFF};
    vecs[18] = '{1'b0, 4'h3, 32'h0,         4'b0000, 32'h0,        1'b0, 8'h77, 8'hFF};

    PRESETn = 1'b0;
    psel1 = 1'b0;
    psel3 = 1'b0;
    PENABLE = 1'b0;
    PWRITE = 1'b0;
    PADDR = '0;
    PWDATA = '0;
    PSTRB = '0;
    gpioIn = '0;

    #3;
    checkOutput("reset_pready", 32'(pready1), 32'd0);
    checkOutput("reset_pslverr", 32'(pslverr1), 32'd0);
    checkOutput("reset_prdata", prdata1, 32'd0);
    checkOutput("reset_gpio_out", 32'(out1), 32'd0);
    checkOutput("reset_gpio_oe", 32'(oe1), 32'd0);
    checkOutput("reset_irq", 32'(irq1), 32'd0);
    checkOutput("reset3_outs", 32'({out3, oe3, irq3, pready3}), 32'd0);

    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    repeat (2) @(posedge PCLK);

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Synchronised input read-back; rising edges on the new pins latch into IS.
    @(posedge PCLK); #1 gpioIn = 8'h5A;
    repeat (3) @(posedge PCLK);
    apbXfer(1, 1'b0, 4'h2, 32'h0, 4'h0, 1'b0, 8'h00, rd, err, waits);
    checkOutput("din_read", rd, 32'h0000_005A);
    checkOutput("din_read_err", 32'(err), 32'd0);
    apbXfer(1, 1'b0, 4'h4, 32'h0, 4'h0, 1'b0, 8'h00, rd, err, waits);
    checkOutput("is_after_pins", rd, 32'h0000_005A);
    checkOutput("irq_masked", 32'(irq1), 32'd0);
    apbXfer(1, 1'b1, 4'h4, 32'h0000_00FF, 4'b0001, 1'b0, 8'h00, rd, err, waits);
    apbXfer(1, 1'b0, 4'h4, 32'h0, 4'h0, 1'b0, 8'h00, rd, err, waits);
    checkOutput("is_cleared_all", rd, 32'h0);

    // Enabled rising edge on pin 0: two sync flops, IS, then registered irq.
    apbXfer(1, 1'b1, 4'h3, 32'h0000_0001, 4'b0001, 1'b0, 8'h00, rd, err, waits);
    checkOutput("irq_before_edge", 32'(irq1), 32'd0);
    @(posedge PCLK); #1 gpioIn = 8'h5B;
    lat = -1;
    for (int n = 0; n < 8; n++) begin
      @(negedge PCLK);
      if (irq1 && lat < 0) lat = n;
    end
    checkOutput("irq_latency", 32'(lat), 32'd4);
    apbXfer(1, 1'b0, 4'h4, 32'h0, 4'h0, 1'b0, 8'h00, rd, err, waits);
    checkOutput("is_bit0_set", rd, 32'h0000_0001);
    apbXfer(1, 1'b1, 4'h4, 32'h0000_0001, 4'b0001, 1'b0, 8'h00, rd, err, waits);
    @(negedge PCLK);
    @(negedge PCLK);
    checkOutput("irq_after_clear", 32'(irq1), 32'd0);
    apbXfer(1, 1'b0, 4'h4, 32'h0, 4'h0, 1'b0, 8'h00, rd, err, waits);
    checkOutput("is_after_clear", rd, 32'h0);

    // Re-arm IS, then clear it on the very edge a new rising edge lands.
    @(posedge PCLK); #1 gpioIn = 8'h5A;
    repeat (5) @(posedge PCLK);
    #1 gpioIn = 8'h5B;
    repeat (6) @(posedge PCLK);
    apbXfer(1, 1'b0, 4'h4, 32'h0, 4'h0, 1'b0, 8'h00, rd, err, waits);
    checkOutput("is_rearmed", rd, 32'h0000_0001);
    @(posedge PCLK); #1 gpioIn = 8'h5A;
    repeat (5) @(posedge PCLK);
    apbXfer(1, 1'b1, 4'h4, 32'h0000_0001, 4'b0001, 1'b1, 8'h5B, rd, err, waits);
    checkOutput("set_wins_err", 32'(err), 32'd0);
    apbXfer(1, 1'b0, 4'h4, 32'h0, 4'h0, 1'b0, 8'h00, rd, err, waits);
    checkOutput("set_wins_is", rd, 32'h0000_0001);
    checkOutput("set_wins_irq", 32'(irq1), 32'd1);

    // Abort on the 3-wait-state instance: drop PSEL while still waiting.
    @(posedge PCLK); #1;
    psel3 = 1'b1;
    PENABLE = 1'b0;
    PWRITE = 1'b1;
    PADDR = 4'h0;
    PWDATA = 32'h0000_00FF;
    PSTRB = 4'b1111;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    sawReady = 1'b0;
    @(negedge PCLK);
    if (pready3) sawReady = 1'b1;
    @(posedge PCLK); #1;
    psel3 = 1'b0;
    PENABLE = 1'b0;
    repeat (4) begin
      @(negedge PCLK);
      if (pready3) sawReady = 1'b1;
    end
    checkOutput("abort_no_pready", 32'(sawReady), 32'd0);
    checkOutput("abort_no_write", 32'(out3), 32'd0);
    apbXfer(3, 1'b1, 4'h0, 32'h0000_0033, 4'b0001, 1'b0, 8'h00, rd, err, waits);
    checkOutput("ws3_write_waits", 32'(waits), 32'd3);
    checkOutput("ws3_gpio_out", 32'(out3), 32'h33);
    apbXfer(3, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 8'h00, rd, err, waits);
    checkOutput("ws3_read", rd, 32'h0000_0033);
    checkOutput("ws3_read_waits", 32'(waits), 32'd3);

    // Reset in the middle of a READY read with all pins high.
    @(posedge PCLK); #1 gpioIn = 8'hFF;
    repeat (5) @(posedge PCLK);
    #1;
    psel1 = 1'b1;
    PENABLE = 1'b0;
    PWRITE = 1'b0;
    PADDR = 4'h0;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1;
    checkOutput("pre_reset_pready", 32'(pready1), 32'd1);
    checkOutput("pre_reset_prdata", prdata1, 32'h0000_0077);
    checkOutput("pre_reset_irq", 32'(irq1), 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    checkOutput("mid_reset_pready", 32'(pready1), 32'd0);
    checkOutput("mid_reset_pslverr", 32'(pslverr1), 32'd0);
    checkOutput("mid_reset_prdata", prdata1, 32'd0);
    checkOutput("mid_reset_gpio_out", 32'(out1), 32'd0);
    checkOutput("mid_reset_gpio_oe", 32'(oe1), 32'd0);
    checkOutput("mid_reset_irq", 32'(irq1), 32'd0);
    psel1 = 1'b0;
    PENABLE = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    repeat (8) @(posedge PCLK);
    apbXfer(1, 1'b0, 4'h4, 32'h0, 4'h0, 1'b0, 8'h00, rd, err, waits);
    checkOutput("prime_is_clear", rd, 32'h0);
    apbXfer(1, 1'b0, 4'h2, 32'h0, 4'h0, 1'b0, 8'h00, rd, err, waits);
    checkOutput("prime_din", rd, 32'h0000_00FF);
    checkOutput("prime_irq", 32'(irq1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_gpio_slave.md
Name: apb_gpio_slave

Overview:
- APB slave on PSEL[0]; consumes PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB from the APB bus master and returns PRDATA/PREADY/PSLVERR.
- Provides a word-indexed GPIO register file: output data, direction, synchronised input, and an edge-detect interrupt with enable/status.
- Configurable wait-state insertion so the master's PREADY stall path is exercised.

Parameters:
- DATA_WIDTH, 32, APB data width.
- ADDRESS_WIDTH, 4, APB address width; PADDR[2:0] = register index; PADDR[3] ignored (bus-side slave select).
- STRB_WIDTH, 4, byte strobes (DATA_WIDTH/8).
- GPIO_WIDTH, 8, pin count, 1..DATA_WIDTH.
- WAIT_STATES, 1, PREADY-low cycles per access phase, 0..15.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  this slave's select bit.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  ADDRESS_WIDTH  address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  STRB_WIDTH  write byte enables.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error.
- gpio_in  in  GPIO_WIDTH  asynchronous pins.
- gpio_out  out  GPIO_WIDTH  DOUT register.
- gpio_oe  out  GPIO_WIDTH  DIR register, 1 = drive.
- irq  out  1  level interrupt.

Behaviour:
- Reset (async, PRESETn=0): FSM=IDLE, wait counter=0, DOUT=0, DIR=0, IE=0, IS=0, POL=0, sync flops=0, prime counter=0. Outputs: PREADY=0, PSLVERR=0, PRDATA=0, gpio_out=0, gpio_oe=0, irq=0.
- Register map by PADDR[2:0]:
  - 0 DOUT RW.
  - 1 DIR RW.
  - 2 DIN RO (synchronised pins).
  - 3 IE RW.
  - 4 IS W1C.
  - 5 POL RW (0 = rising, 1 = falling).
  - 6, 7 reserved.
  - Register bits above GPIO_WIDTH read 0 and ignore writes.
- FSM states IDLE, WAIT, READY; all transitions evaluated on PCLK rising edge:
  - IDLE: PSEL & !PENABLE (setup) -> WAIT with cnt = WAIT_STATES, or -> READY if WAIT_STATES = 0.
  - WAIT: !PSEL -> IDLE (abort, no side effects). Otherwise cnt decrements; cnt = 1 -> READY.
  - READY: -> IDLE unconditionally. The next setup phase is therefore seen in IDLE, so back-to-back transfers work.
- PREADY = (state == READY) & PSEL & PENABLE, combinational from the state register. Access phase lasts WAIT_STATES+1 cycles.
- PSLVERR = PREADY & (index in {6,7} | (PWRITE & index == 2)). An error transfer changes no register.
- PRDATA = selected register, zero-extended, when PREADY & !PWRITE; else 0. Reads have no side effects.
- Write commit on the edge where PREADY & PWRITE & !PSLVERR:
  - Only byte lanes with PSTRB[i]=1 update.
  - PSTRB = 0: no change, no error.
- Input path: 2-flop synchroniser -> din; din_q = din delayed 1 cycle.
  - Edge per bit: POL=0: din & !din_q; POL=1: !din & din_q.
- Prime counter saturates at 3 after reset. Edge detection is suppressed until it saturates, so a pin high at reset never sets IS.
- IS[i] is set on edge regardless of IE. irq = |(IS & IE), registered (1-cycle latency from IS).
- Simultaneous W1C clear and new edge on the same bit: set wins.
- Writing POL may create an apparent edge on the next cycle; this is accepted, and software clears IS after changing POL.
- DIN reflects pins irrespective of DIR.

Decomposition:
- Shared package apb_pkg: FSM state encoding, register index constants (REG_DOUT=0 .. REG_POL=5), a strobe-merge function (old, new, strb) -> merged word.
- One sub-module: gpio_in_sync (2-flop synchroniser + delayed copy + edge detector, GPIO_WIDTH-wide, POL input, edge output). Register file and FSM stay in apb_gpio_slave.

Test Plan:
- Write DOUT=0x000000A5, PSTRB=4'b0001, WAIT_STATES=1 -> PREADY low 1 access cycle then high; gpio_out=0xA5 next cycle; PSLVERR=0.
- DIR=0xFF, then write DOUT=0x3C with PSTRB=0 -> gpio_out unchanged 0xA5; read DOUT returns 0xA5.
- Drive gpio_in=0x5A, wait 3 cycles, read index 2 -> PRDATA=0x0000005A. Write index 2 -> PSLVERR=1, no state change. Access index 7 -> PSLVERR=1, PRDATA=0.
- IE=0x01, POL=0, gpio_in[0] 0->1 -> IS=0x01 within 3 cycles, irq=1. Write IS=0x01 -> IS=0, irq=0. Repeat with the edge on the clear cycle -> IS stays 1.
- PSEL dropped during WAIT (WAIT_STATES=3) -> FSM returns IDLE, no write, PREADY never high. Next transfer completes normally.
- Assert PRESETn low mid-access with gpio_in=0xFF held -> all outputs 0 immediately. After release, IS remains 0 (prime suppression).
